// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
//
// Supervises a PLL from its reference clock domain. The block pulses the PLL
// reset for a fixed number of cycles, waits for the PLL locked indication,
// requires lock to stay up for a stable window, and only then releases the
// system reset. A PLL that does not lock in time is retried. After
// MAX_RETRIES timeouts the block parks in FAIL until force_relock or rst.
// A lock loss while running restarts the whole sequence and is counted.
//
// Ports
//   refclk        in   1  reference clock, the only clock of this block
//   rst           in   1  asynchronous active-high reset
//   locked        in   1  PLL locked, asynchronous, synchronised internally
//   force_relock  in   1  single-cycle request to restart the lock sequence
//   pll_rst       out  1  PLL reset, active-high
//   sys_rst       out  1  system reset, active-high, low only in RUN
//   ready         out  1  lock achieved and stable, always ~sys_rst
//   lock_fail     out  1  sticky, set when MAX_RETRIES timeouts occurred
//   retry_cnt     out  4  lock timeouts since last RUN entry / force_relock
//   loss_cnt      out  8  lock losses seen in RUN, saturating at 255
//   state_o       out  3  current state for debug
//
// Parameters
//   PLL_RST_CYCLES  width of each pll_rst pulse in refclk cycles (>= 1)
//   LOCK_TIMEOUT    cycles to wait for lock after pll_rst release
//   LOCK_STABLE     cycles locked must stay high before release
//   MAX_RETRIES     timeouts tolerated before FAIL (1..15)
//   CNT_W           shared cycle counter width
// -----------------------------------------------------------------------------
module pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 125000,
  parameter int LOCK_STABLE    = 1024,
  parameter int MAX_RETRIES    = 7,
  parameter int CNT_W          = 20
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       lock_fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  // Terminal counts: the counter starts at zero on entry to each timed
  // state, so the last cycle of a window of N cycles sees N-1.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  // Saturating increment for the lock-loss counter.
  function automatic logic [7:0] sat_inc_loss(input logic [7:0] val);
    if (val == 8'hFF) begin
      return val;
    end
    return val + 8'd1;
  endfunction

  // Retry counter increment; MAX_RETRIES <= 15 keeps this from wrapping
  // because FAIL is entered when the limit is reached.
  function automatic logic [3:0] inc_retry(input logic [3:0] val);
    return val + 4'd1;
  endfunction

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [3:0]       retry_n;
  logic [7:0]       loss_n;
  logic             fail_n;

  logic             locked_p0;
  logic             locked_p1;
  logic             locked_s;

  // ---- stage p0/p1: two-flop synchroniser for the asynchronous locked ----
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      locked_p0 <= 1'b0;
      locked_p1 <= 1'b0;
    end else begin
      locked_p0 <= locked;
      locked_p1 <= locked_p0;
    end
  end

  assign locked_s = locked_p1;

  // ---- next-state decision from the synchronised lock indication ----
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    retry_n = retry_cnt;
    loss_n  = loss_cnt;
    fail_n  = lock_fail;

    if (force_relock) begin
      // Restart request overrides every other transition; loss history kept.
      state_n = S_PLL_RST;
      cnt_n   = '0;
      retry_n = 4'd0;
      fail_n  = 1'b0;
    end else begin
      unique case (state)
        S_PLL_RST: begin
          if (cnt == RST_LAST) begin
            state_n = S_WAIT_LOCK;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end

        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_n = S_STABLE;
            cnt_n   = '0;
          end else if (cnt == TIMEOUT_LAST) begin
            retry_n = inc_retry(retry_cnt);
            cnt_n   = '0;
            if (retry_n == RETRY_LIMIT) begin
              state_n = S_FAIL;
              fail_n  = 1'b1;
            end else begin
              state_n = S_PLL_RST;
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end

        S_STABLE: begin
          // A glitch in lock sends us back to waiting with a fresh timeout
          // window; it is not counted as a retry.
          if (!locked_s) begin
            state_n = S_WAIT_LOCK;
            cnt_n   = '0;
          end else if (cnt == STABLE_LAST) begin
            state_n = S_RUN;
            cnt_n   = '0;
            retry_n = 4'd0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end

        S_RUN: begin
          cnt_n = '0;
          if (!locked_s) begin
            state_n = S_PLL_RST;
            loss_n  = sat_inc_loss(loss_cnt);
          end
        end

        S_FAIL: begin
          cnt_n = '0;
        end

        default: begin
          state_n = S_PLL_RST;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // ---- stage boundary: state, counters and registered outputs ----
  // Outputs are decoded from the next state so they switch on the same
  // edge as the state register.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state     <= S_PLL_RST;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      lock_fail <= 1'b0;
      retry_cnt <= 4'd0;
      loss_cnt  <= 8'd0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pll_rst   <= (state_n == S_PLL_RST);
      sys_rst   <= (state_n != S_RUN);
      ready     <= (state_n == S_RUN);
      lock_fail <= fail_n;
      retry_cnt <= retry_n;
      loss_cnt  <= loss_n;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
module tb_pll_lock_supervisor;

  localparam int T_RST     = 4;
  localparam int T_TIMEOUT = 20;
  localparam int T_STABLE  = 8;
  localparam int T_MAX     = 3;

  localparam logic [2:0] PH_RST    = 3'd0;
  localparam logic [2:0] PH_WAIT   = 3'd1;
  localparam logic [2:0] PH_STABLE = 3'd2;
  localparam logic [2:0] PH_RUN    = 3'd3;
  localparam logic [2:0] PH_FAIL   = 3'd4;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       force_relock = 1'b0;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       lock_fail;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] state_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural reference: elapsed-cycle counts per phase and a history of
  // sampled locked values standing in for the synchroniser delay.
  logic       m_hist[$];
  logic [2:0] m_phase;
  int         m_elapsed;
  logic [3:0] m_retries;
  logic [7:0] m_losses;
  logic       m_fail;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES(T_RST),
    .LOCK_TIMEOUT(T_TIMEOUT),
    .LOCK_STABLE(T_STABLE),
    .MAX_RETRIES(T_MAX),
    .CNT_W(20)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .locked(locked),
    .force_relock(force_relock),
    .pll_rst(pll_rst),
    .sys_rst(sys_rst),
    .ready(ready),
    .lock_fail(lock_fail),
    .retry_cnt(retry_cnt),
    .loss_cnt(loss_cnt),
    .state_o(state_o)
  );

  always #4 refclk = ~refclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, n_tests=%0d required finish", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    locked = 1'b0;
    force_relock = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic model_reset();
    m_hist.delete();
    m_hist.push_back(1'b0);
    m_hist.push_back(1'b0);
    m_phase = PH_RST;
    m_elapsed = 0;
    m_retries = 4'd0;
    m_losses = 8'd0;
    m_fail = 1'b0;
  endtask

  // One refclk edge of the reference: lk/fr are the inputs present before it.
  task automatic model_step(input logic lk, input logic fr);
    logic ls;
    ls = m_hist[0];
    void'(m_hist.pop_front());
    m_hist.push_back(lk);
    if (fr) begin
      m_phase = PH_RST;
      m_elapsed = 0;
      m_retries = 4'd0;
      m_fail = 1'b0;
    end else begin
      case (m_phase)
        PH_RST: begin
          m_elapsed++;
          if (m_elapsed == T_RST) begin
            m_phase = PH_WAIT;
            m_elapsed = 0;
          end
        end
        PH_WAIT: begin
          if (ls) begin
            m_phase = PH_STABLE;
            m_elapsed = 0;
          end else begin
            m_elapsed++;
            if (m_elapsed == T_TIMEOUT) begin
              m_elapsed = 0;
              m_retries++;
              if (m_retries == 4'(T_MAX)) begin
                m_phase = PH_FAIL;
                m_fail = 1'b1;
              end else begin
                m_phase = PH_RST;
              end
            end
          end
        end
        PH_STABLE: begin
          if (!ls) begin
            m_phase = PH_WAIT;
            m_elapsed = 0;
          end else begin
            m_elapsed++;
            if (m_elapsed == T_STABLE) begin
              m_phase = PH_RUN;
              m_elapsed = 0;
              m_retries = 4'd0;
            end
          end
        end
        PH_RUN: begin
          if (!ls) begin
            m_phase = PH_RST;
            m_elapsed = 0;
            if (m_losses != 8'd255) m_losses++;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    locked = 1'b0;
    force_relock = 1'b0;
    tick();
    tick();
    n_tests++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL reset_pll_rst got %b want 1", pll_rst); end
    n_tests++; if (sys_rst !== 1'b1) begin n_fail++; $display("FAIL reset_sys_rst got %b want 1", sys_rst); end
    n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", ready); end
    n_tests++; if (lock_fail !== 1'b0) begin n_fail++; $display("FAIL reset_lock_fail got %b want 0", lock_fail); end
    n_tests++; if (retry_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_retry got %0d want 0", retry_cnt); end
    n_tests++; if (loss_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_loss got %0d want 0", loss_cnt); end
    n_tests++; if (state_o !== PH_RST) begin n_fail++; $display("FAIL reset_state got %0d want 0", state_o); end
  endtask

  // Called right after reset release: pulse width, then lock 10 cycles later.
  task automatic run_lock_sequence(input string tag);
    int n;
    int e;
    n = 0;
    if (pll_rst) n++;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pll_rst) n++;
      else break;
    end
    n_tests++; if (n !== T_RST) begin n_fail++; $display("FAIL %s_pll_rst_width got %0d want %0d", tag, n, T_RST); end
    for (int i = 0; i < 10; i++) tick();
    locked = 1'b1;
    e = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      e++;
      if (ready) break;
    end
    n_tests++; if (e !== 11) begin n_fail++; $display("FAIL %s_ready_edge got %0d want 11", tag, e); end
    n_tests++; if (sys_rst !== 1'b0) begin n_fail++; $display("FAIL %s_sys_rst got %b want 0", tag, sys_rst); end
    n_tests++; if (retry_cnt !== 4'd0) begin n_fail++; $display("FAIL %s_retry got %0d want 0", tag, retry_cnt); end
    n_tests++; if (state_o !== PH_RUN) begin n_fail++; $display("FAIL %s_state got %0d want 3", tag, state_o); end
  endtask

  task automatic test_lock_sequence();
    do_reset();
    run_lock_sequence("lock_seq");
  endtask

  task automatic test_timeout_fail();
    logic s[160];
    int   lens[$];
    logic vals[$];
    logic cur;
    int   len;
    do_reset();
    s[0] = pll_rst;
    for (int i = 1; i < 160; i++) begin
      tick();
      s[i] = pll_rst;
    end
    cur = s[0];
    len = 1;
    for (int i = 1; i < 160; i++) begin
      if (s[i] == cur) len++;
      else begin
        vals.push_back(cur); lens.push_back(len);
        cur = s[i]; len = 1;
      end
    end
    vals.push_back(cur); lens.push_back(len);
    n_tests++; if (vals.size() !== 6) begin n_fail++; $display("FAIL timeout_runs got %0d want 6", vals.size()); end
    n_tests++; if (vals[0] !== 1'b1) begin n_fail++; $display("FAIL timeout_first_level got %b want 1", vals[0]); end
    if (lens.size() >= 5) begin
      for (int r = 0; r < 5; r++) begin
        n_tests++;
        if (lens[r] !== ((r % 2 == 0) ? T_RST : T_TIMEOUT)) begin
          n_fail++;
          $display("FAIL timeout_run%0d_len got %0d want %0d", r, lens[r], (r % 2 == 0) ? T_RST : T_TIMEOUT);
        end
      end
    end
    n_tests++; if (state_o !== PH_FAIL) begin n_fail++; $display("FAIL timeout_state got %0d want 4", state_o); end
    n_tests++; if (lock_fail !== 1'b1) begin n_fail++; $display("FAIL timeout_lock_fail got %b want 1", lock_fail); end
    n_tests++; if (retry_cnt !== 4'd3) begin n_fail++; $display("FAIL timeout_retry got %0d want 3", retry_cnt); end
    n_tests++; if (sys_rst !== 1'b1) begin n_fail++; $display("FAIL timeout_sys_rst got %b want 1", sys_rst); end
    for (int i = 0; i < 50; i++) tick();
    n_tests++; if (state_o !== PH_FAIL) begin n_fail++; $display("FAIL timeout_hold_state got %0d want 4", state_o); end
    n_tests++; if (pll_rst !== 1'b0) begin n_fail++; $display("FAIL timeout_hold_pll_rst got %b want 0", pll_rst); end
  endtask

  task automatic test_stable_glitch();
    int k;
    do_reset();
    for (int i = 0; i < 100; i++) begin
      if (retry_cnt == 4'd1 && state_o == PH_WAIT) break;
      tick();
    end
    n_tests++; if (retry_cnt !== 4'd1) begin n_fail++; $display("FAIL glitch_pre_retry got %0d want 1", retry_cnt); end
    locked = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (state_o == PH_STABLE) break;
      tick();
    end
    n_tests++; if (state_o !== PH_STABLE) begin n_fail++; $display("FAIL glitch_enter_stable got %0d want 2", state_o); end
    for (int i = 0; i < 3; i++) tick();
    locked = 1'b0;
    tick();
    locked = 1'b1;
    tick();
    tick();
    k = 6;
    n_tests++; if (state_o !== PH_WAIT) begin n_fail++; $display("FAIL glitch_back_to_wait got %0d want 1", state_o); end
    n_tests++; if (retry_cnt !== 4'd1) begin n_fail++; $display("FAIL glitch_retry got %0d want 1", retry_cnt); end
    tick();
    k = 7;
    n_tests++; if (state_o !== PH_STABLE) begin n_fail++; $display("FAIL glitch_relock got %0d want 2", state_o); end
    while (!ready && k < 40) begin
      tick();
      k++;
    end
    n_tests++; if (k !== 15) begin n_fail++; $display("FAIL glitch_ready_edge got %0d want 15", k); end
  endtask

  task automatic test_loss_counter();
    int n;
    int want;
    do_reset();
    locked = 1'b1;
    for (int i = 0; i < 60 && !ready; i++) tick();
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL loss_initial_ready got %b want 1", ready); end
    for (int it = 0; it < 260; it++) begin
      locked = 1'b0;
      tick();
      tick();
      n_tests++; if (sys_rst !== 1'b0) begin n_fail++; $display("FAIL loss%0d_early_sys_rst got %b want 0", it, sys_rst); end
      tick();
      n_tests++; if (sys_rst !== 1'b1 || ready !== 1'b0) begin n_fail++; $display("FAIL loss%0d_drop got sys_rst=%b ready=%b want 1/0", it, sys_rst, ready); end
      want = (it + 1 > 255) ? 255 : it + 1;
      n_tests++; if (loss_cnt !== 8'(want)) begin n_fail++; $display("FAIL loss%0d_count got %0d want %0d", it, loss_cnt, want); end
      n = 0;
      if (pll_rst) n++;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (pll_rst) n++;
        else break;
      end
      n_tests++; if (n !== T_RST) begin n_fail++; $display("FAIL loss%0d_pulse got %0d want %0d", it, n, T_RST); end
      locked = 1'b1;
      for (int i = 0; i < 60 && !ready; i++) tick();
      n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL loss%0d_relock got %b want 1", it, ready); end
    end
    n_tests++; if (loss_cnt !== 8'd255) begin n_fail++; $display("FAIL loss_saturate got %0d want 255", loss_cnt); end
  endtask

  task automatic test_force_relock();
    int n;
    do_reset();
    for (int i = 0; i < 200 && state_o != PH_FAIL; i++) tick();
    n_tests++; if (state_o !== PH_FAIL) begin n_fail++; $display("FAIL force_reach_fail got %0d want 4", state_o); end
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    n_tests++; if (state_o !== PH_RST || pll_rst !== 1'b1) begin n_fail++; $display("FAIL force_restart got state=%0d pll_rst=%b want 0/1", state_o, pll_rst); end
    n_tests++; if (lock_fail !== 1'b0) begin n_fail++; $display("FAIL force_lock_fail got %b want 0", lock_fail); end
    n_tests++; if (retry_cnt !== 4'd0) begin n_fail++; $display("FAIL force_retry got %0d want 0", retry_cnt); end
    n = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pll_rst) n++;
      else break;
    end
    n_tests++; if (n !== T_RST) begin n_fail++; $display("FAIL force_pulse got %0d want %0d", n, T_RST); end
    for (int i = 0; i < 60; i++) begin
      if (state_o == PH_WAIT && retry_cnt == 4'd1) break;
      tick();
    end
    for (int i = 0; i < T_TIMEOUT - 1; i++) tick();
    n_tests++; if (state_o !== PH_WAIT || retry_cnt !== 4'd1) begin n_fail++; $display("FAIL force_pre_timeout got state=%0d retry=%0d want 1/1", state_o, retry_cnt); end
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    n_tests++; if (state_o !== PH_RST || pll_rst !== 1'b1) begin n_fail++; $display("FAIL force_at_timeout got state=%0d pll_rst=%b want 0/1", state_o, pll_rst); end
    n_tests++; if (retry_cnt !== 4'd0) begin n_fail++; $display("FAIL force_at_timeout_retry got %0d want 0", retry_cnt); end
  endtask

  task automatic test_async_reset();
    do_reset();
    locked = 1'b1;
    for (int i = 0; i < 40 && state_o != PH_STABLE; i++) tick();
    n_tests++; if (state_o !== PH_STABLE) begin n_fail++; $display("FAIL async_reach_stable got %0d want 2", state_o); end
    #2;
    rst = 1'b1;
    #1;
    n_tests++; if (pll_rst !== 1'b1 || sys_rst !== 1'b1) begin n_fail++; $display("FAIL async_outputs got pll_rst=%b sys_rst=%b want 1/1", pll_rst, sys_rst); end
    n_tests++; if (state_o !== PH_RST) begin n_fail++; $display("FAIL async_state got %0d want 0", state_o); end
    locked = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    run_lock_sequence("async_relock");
  endtask

  task automatic test_random();
    int run_left;
    do_reset();
    model_reset();
    run_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (run_left == 0) begin
        locked = ~locked;
        if (locked && $urandom_range(0, 3) == 0) run_left = $urandom_range(60, 120);
        else run_left = $urandom_range(1, 40);
      end
      run_left--;
      force_relock = ($urandom_range(0, 149) == 0);
      tick();
      model_step(locked, force_relock);
      n_tests++; if (pll_rst !== (m_phase == PH_RST)) begin n_fail++; $display("FAIL rand%0d_pll_rst got %b want %b", c, pll_rst, (m_phase == PH_RST)); end
      n_tests++; if (sys_rst !== (m_phase != PH_RUN)) begin n_fail++; $display("FAIL rand%0d_sys_rst got %b want %b", c, sys_rst, (m_phase != PH_RUN)); end
      n_tests++; if (ready !== (m_phase == PH_RUN)) begin n_fail++; $display("FAIL rand%0d_ready got %b want %b", c, ready, (m_phase == PH_RUN)); end
      n_tests++; if (lock_fail !== m_fail) begin n_fail++; $display("FAIL rand%0d_lock_fail got %b want %b", c, lock_fail, m_fail); end
      n_tests++; if (retry_cnt !== m_retries) begin n_fail++; $display("FAIL rand%0d_retry got %0d want %0d", c, retry_cnt, m_retries); end
      n_tests++; if (loss_cnt !== m_losses) begin n_fail++; $display("FAIL rand%0d_loss got %0d want %0d", c, loss_cnt, m_losses); end
      n_tests++; if (state_o !== m_phase) begin n_fail++; $display("FAIL rand%0d_state got %0d want %0d", c, state_o, m_phase); end
    end
    force_relock = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lock_sequence();
    test_timeout_fail();
    test_stable_glitch();
    test_loss_counter();
    test_force_relock();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
